// File: rtl/calckit_pkg.sv
// Shared constants and the reader FSM state encoding for the calculator kit.
package calckit_pkg;

  localparam int DEF_DATA_W = 16;  // storage element width
  localparam int DEF_IDX_W  = 3;   // row/column/dimension width
  localparam int DEF_SLOT_W = 2;   // storage slot index width
  localparam int MAX_DIM    = 7;   // largest legal row or column count

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIM_WAIT = 2'd1,
    EL_WAIT  = 2'd2,
    EL_OUT   = 2'd3
  } rd_state_e;

endpackage

// File: rtl/matrix_reader_if.sv
// Bundle for matrix_reader: control, storage read port and output beat stream.
// The master modport is the reader itself; slave is the surrounding system.
interface matrix_reader_if
  import calckit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int SLOT_W = DEF_SLOT_W
);

  // control
  logic              start;
  logic [SLOT_W-1:0] src_slot;
  logic              busy;
  logic              done;
  logic              err;

  // storage read port (dimensions and elements)
  logic              dim_rd_en;
  logic [SLOT_W-1:0] rd_slot_idx;
  logic [IDX_W-1:0]  dim_m;
  logic [IDX_W-1:0]  dim_n;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_row;
  logic [IDX_W-1:0]  rd_col;
  logic [DATA_W-1:0] rd_data;

  // output beat stream
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_row;
  logic [IDX_W-1:0]  out_col;
  logic              out_row_last;
  logic              out_last;

  modport master (
    input  start, src_slot, dim_m, dim_n, rd_data, out_ready,
    output busy, done, err, dim_rd_en, rd_slot_idx, rd_en, rd_row, rd_col,
           out_valid, out_data, out_row, out_col, out_row_last, out_last
  );

  modport slave (
    output start, src_slot, dim_m, dim_n, rd_data, out_ready,
    input  busy, done, err, dim_rd_en, rd_slot_idx, rd_en, rd_row, rd_col,
           out_valid, out_data, out_row, out_col, out_row_last, out_last
  );

endinterface

// File: rtl/matrix_reader.sv
// Reads one storage slot: fetches its dimensions, then streams every element
// in row-major order on a valid/ready interface. Storage reads have one cycle
// of latency, so each wait state spends one cycle with its strobe high and
// samples the returned value on the following edge.
module matrix_reader
  import calckit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  matrix_reader_if.master  bus
);

  localparam logic [IDX_W-1:0] IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  rd_state_e         state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              dim_rd_en_q, dim_rd_en_d;
  logic              rd_en_q, rd_en_d;
  logic [SLOT_W-1:0] rd_slot_idx_q, rd_slot_idx_d;
  logic [IDX_W-1:0]  m_l_q, m_l_d;
  logic [IDX_W-1:0]  n_l_q, n_l_d;
  logic [IDX_W-1:0]  i_q, i_d;     // walker row, doubles as rd_row
  logic [IDX_W-1:0]  j_q, j_d;     // walker column, doubles as rd_col
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]  out_row_q, out_row_d;
  logic [IDX_W-1:0]  out_col_q, out_col_d;
  logic              out_row_last_q, out_row_last_d;
  logic              out_last_q, out_last_d;

  // State register and all registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      dim_rd_en_q    <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_slot_idx_q  <= '0;
      m_l_q          <= '0;
      n_l_q          <= '0;
      i_q            <= '0;
      j_q            <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      out_row_last_q <= 1'b0;
      out_last_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      dim_rd_en_q    <= dim_rd_en_d;
      rd_en_q        <= rd_en_d;
      rd_slot_idx_q  <= rd_slot_idx_d;
      m_l_q          <= m_l_d;
      n_l_q          <= n_l_d;
      i_q            <= i_d;
      j_q            <= j_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_row_q      <= out_row_d;
      out_col_q      <= out_col_d;
      out_row_last_q <= out_row_last_d;
      out_last_q     <= out_last_d;
    end
  end

  // Next-state logic: sequencing, walker advance and beat capture
  always_comb begin
    state_d        = state_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    dim_rd_en_d    = 1'b0;
    rd_en_d        = 1'b0;
    rd_slot_idx_d  = rd_slot_idx_q;
    m_l_d          = m_l_q;
    n_l_d          = n_l_q;
    i_d            = i_q;
    j_d            = j_q;
    out_valid_d    = out_valid_q;
    out_data_d     = out_data_q;
    out_row_d      = out_row_q;
    out_col_d      = out_col_q;
    out_row_last_d = out_row_last_q;
    out_last_d     = out_last_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rd_slot_idx_d = bus.src_slot;
          busy_d        = 1'b1;
          dim_rd_en_d   = 1'b1;
          state_d       = DIM_WAIT;
        end
      end

      DIM_WAIT: begin
        // strobe cycle first; dimensions are returned the cycle after it
        if (!dim_rd_en_q) begin
          m_l_d = bus.dim_m;
          n_l_d = bus.dim_n;
          if (bus.dim_m == IDX_ZERO || bus.dim_n == IDX_ZERO) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            i_d     = '0;
            j_d     = '0;
            rd_en_d = 1'b1;
            state_d = EL_WAIT;
          end
        end
      end

      EL_WAIT: begin
        if (!rd_en_q) begin
          out_data_d     = bus.rd_data;
          out_row_d      = i_q;
          out_col_d      = j_q;
          out_row_last_d = (j_q == n_l_q - IDX_ONE);
          out_last_d     = (i_q == m_l_q - IDX_ONE) && (j_q == n_l_q - IDX_ONE);
          out_valid_d    = 1'b1;
          state_d        = EL_OUT;
        end
      end

      EL_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            // compare against the latched width before incrementing so a
            // full 7-wide row never needs an eighth column value
            if (j_q == n_l_q - IDX_ONE) begin
              j_d = '0;
              i_d = i_q + IDX_ONE;
            end else begin
              j_d = j_q + IDX_ONE;
            end
            rd_en_d = 1'b1;
            state_d = EL_WAIT;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.dim_rd_en    = dim_rd_en_q;
  assign bus.rd_slot_idx  = rd_slot_idx_q;
  assign bus.rd_en        = rd_en_q;
  assign bus.rd_row       = i_q;
  assign bus.rd_col       = j_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_row      = out_row_q;
  assign bus.out_col      = out_col_q;
  assign bus.out_row_last = out_row_last_q;
  assign bus.out_last     = out_last_q;

endmodule

// File: tb/tb_matrix_reader.sv
// Directed bench for matrix_reader with a one-cycle-latency storage model.
module tb_matrix_reader;
  import calckit_pkg::*;

  localparam int DW = DEF_DATA_W;
  localparam int IW = DEF_IDX_W;
  localparam int SW = DEF_SLOT_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_reader_if #(.DATA_W(DW), .IDX_W(IW), .SLOT_W(SW)) bus ();

  matrix_reader #(.DATA_W(DW), .IDX_W(IW), .SLOT_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // storage model: registered read, data valid the cycle after the strobe
  logic [DW-1:0] mem   [4][8][8];
  logic [IW-1:0] mem_m [4];
  logic [IW-1:0] mem_n [4];
  logic [IW-1:0] dm_q = '0;
  logic [IW-1:0] dn_q = '0;
  logic [DW-1:0] rdat_q = '0;

  always_ff @(posedge clk) begin
    if (bus.dim_rd_en) begin
      dm_q <= mem_m[bus.rd_slot_idx];
      dn_q <= mem_n[bus.rd_slot_idx];
    end
    if (bus.rd_en) rdat_q <= mem[bus.rd_slot_idx][bus.rd_row][bus.rd_col];
  end

  assign bus.dim_m   = dm_q;
  assign bus.dim_n   = dn_q;
  assign bus.rd_data = rdat_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, {24'd0, bus.busy, bus.done, bus.err, bus.dim_rd_en,
                         bus.rd_en, bus.out_valid, bus.out_row_last, bus.out_last}, 32'd0);
    chk({tag, "_addr"}, {22'd0, bus.rd_slot_idx, bus.rd_row, bus.rd_col}, 32'd0);
    chk({tag, "_beat"}, {10'd0, bus.out_data, bus.out_row, bus.out_col}, 32'd0);
  endtask

  // One transfer. stall_beat: beat index held with out_ready low for 5 cycles.
  // abort_beat: beat index at which reset is asserted (task returns in reset).
  // alt_start: pulse start with slot 3 while busy.
  task automatic read_check(input int slot, input int m, input int n,
                            input int stall_beat, input int abort_beat, input bit alt_start);
    int  beat = 0, rd_cnt = 0, dim_cnt = 0, stall_cnt = 0, k_hs = -1, k_done = -1;
    bit  first = 1'b1, seen_valid = 1'b0;
    bit  zero = (m == 0 || n == 0);
    int  er, ec;
    logic [DW-1:0] ed;

    @(negedge clk);
    bus.start     = 1'b1;
    bus.src_slot  = SW'(slot);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.src_slot = SW'(slot ^ 1);   // must not affect the running transfer

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (alt_start) begin
        if (k == 6) begin
          bus.start    = 1'b1;
          bus.src_slot = 2'd3;
        end else if (k == 7) begin
          bus.start = 1'b0;
        end
      end
      if (k == 0) begin
        chk("busy_on", bus.busy, 1);
        chk("slot_latch", bus.rd_slot_idx, slot);
      end
      if (bus.rd_en) rd_cnt++;
      if (bus.dim_rd_en) dim_cnt++;

      if (bus.out_valid) begin
        seen_valid = 1'b1;
        if (first) begin
          chk("first_latency", k, 4);
          first = 1'b0;
        end
        if (beat == abort_beat) begin
          rst_n = 1'b0;
          #1;
          $display("xfer slot=%0d aborted by reset at beat %0d", slot, beat);
          return;
        end
        er = beat / n;
        ec = beat % n;
        ed = mem[slot][er][ec];
        chk("out_data", bus.out_data, ed);
        chk("out_row", bus.out_row, er);
        chk("out_col", bus.out_col, ec);
        chk("out_row_last", bus.out_row_last, (ec == n - 1));
        chk("out_last", bus.out_last, (beat == m * n - 1));
        chk("slot_hold", bus.rd_slot_idx, slot);
        if (beat == stall_beat && stall_cnt < 5) begin
          bus.out_ready = 1'b0;
          stall_cnt++;
          chk("stall_no_rd_en", bus.rd_en, 0);
        end else begin
          if (k_hs >= 0 && stall_beat < 0) chk("beat_gap", k - k_hs, 3);
          bus.out_ready = 1'b1;
          k_hs = k;
          beat++;
        end
      end

      if (bus.done) begin
        k_done = k;
        chk("err", bus.err, zero);
        chk("busy_off", bus.busy, 0);
        if (zero) chk("zero_done_latency", k, 2);
        else      chk("done_latency", k - k_hs, 1);
        break;
      end
    end

    if (k_done < 0) chk("done_timeout", 0, 1);
    chk("beat_count", beat, m * n);
    chk("rd_en_count", rd_cnt, m * n);
    chk("dim_rd_en_count", dim_cnt, 1);
    chk("valid_seen", seen_valid, !zero);
    if (stall_beat >= 0) chk("stall_cycles", stall_cnt, 5);
    @(negedge clk);
    chk("done_one_cycle", bus.done, 0);
    chk("err_one_cycle", bus.err, 0);
    $display("xfer slot=%0d dims=%0dx%0d beats=%0d err=%0b", slot, m, n, beat, zero);
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++)
          mem[s][r][c] = 16'h5500 + DW'(s * 64 + r * 8 + c);
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        mem[0][r][c] = 16'hA000 + DW'(r * 16 + c);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++)
        mem[1][r][c] = DW'(r * 3 + c + 1);
    mem[3][0][0] = 16'hBEEF;
    mem_m[0] = 3'd7; mem_n[0] = 3'd7;
    mem_m[1] = 3'd2; mem_n[1] = 3'd3;
    mem_m[2] = 3'd0; mem_n[2] = 3'd4;
    mem_m[3] = 3'd1; mem_n[3] = 3'd1;

    bus.start     = 1'b0;
    bus.src_slot  = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    bus.out_ready = 1'b1;     // ready high while idle must be ignored
    repeat (3) @(negedge clk);
    chk("idle_ready_ignored", {bus.busy, bus.out_valid, bus.rd_en}, 3'b000);

    read_check(1, 2, 3, -1, -1, 1'b0);   // 2x3, streaming
    read_check(1, 2, 3,  2, -1, 1'b0);   // 2x3, beat 3 stalled 5 cycles
    read_check(2, 0, 4, -1, -1, 1'b0);   // zero rows -> err
    read_check(3, 1, 1, -1, -1, 1'b0);   // 1x1 0xBEEF
    read_check(0, 7, 7, -1, -1, 1'b1);   // 7x7 with a stray start

    // reset in the middle of beat 10 of a 7x7 read
    read_check(0, 7, 7, -1, 9, 1'b0);
    chk_all_zero("abort");
    repeat (3) begin
      @(negedge clk);
      chk("no_done_in_reset", bus.done, 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_reset", bus.done, 0);
      chk("idle_after_reset", bus.busy, 0);
    end
    read_check(0, 7, 7, -1, -1, 1'b0);   // full read from (0,0) again

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
